fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, instruction-ROM address width.
REQ-002 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-003 SHALL have parameter STEP, default 2, sequential PC increment.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port resetIn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stallIn  input  1  consumer not ready; instruction held while 1.
REQ-007 SHALL have port brReq  input  1  branch/jump redirect request.
REQ-008 SHALL have port brTarget  input  ADDR_W  branch target.
REQ-009 SHALL have port trapReq  input  1  trap redirect request.
REQ-010 SHALL have port trapVec  input  ADDR_W  trap vector.
REQ-011 SHALL have port romReq  output  1  ROM read request.
REQ-012 SHALL have port romAddr  output  ADDR_W  ROM read address.
REQ-013 SHALL have port romAck  input  1  ROM read complete, one-cycle pulse.
REQ-014 SHALL have port instValid  output  1  fetched instruction available to consumer.
REQ-015 SHALL have port instAddr  output  ADDR_W  address of presented instruction.
REQ-016 SHALL have port flushOut  output  1  one-cycle pulse: downstream discard after redirect.
REQ-017 SHALL have port misalignErr  output  1  sticky misaligned-target flag.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, VALID, DRAIN; internal PC register pc separate from romAddr.
REQ-019 IDLE: romReq=0; ignores all requests; goes to FETCH next cycle.
REQ-020 FETCH: romReq=1, romAddr=pc; romReq and romAddr SHALL stay stable until romAck.
REQ-021 FETCH, romAck=1, no redirect: next cycle instValid=1, instAddr=pc, pc=pc+STEP modulo 2^ADDR_W, state VALID, romReq=0.
REQ-022 VALID: instValid and instAddr held; stallIn=0 -> accepted, state FETCH next cycle with romAddr=pc; stallIn=1 -> remain VALID.
REQ-023 Redirect = trapReq or brReq sampled in FETCH or VALID; trapReq has priority, brReq in same cycle dropped.
REQ-024 On redirect: pc=selected target, flushOut=1 for exactly the following cycle, instValid=0 next cycle, regardless of stallIn.
REQ-025 Redirect in VALID, or in FETCH coincident with romAck -> state FETCH; ack data discarded.
REQ-026 Redirect in FETCH without romAck -> state DRAIN; romReq/romAddr held at old address; on romAck discard, go FETCH with new pc.
REQ-027 Redirect in DRAIN SHALL overwrite pc (trap priority), pulse flushOut again, remain DRAIN.
REQ-028 Throughput: at most one instruction per two cycles; ROM wait states unbounded.

Reset
REQ-029 resetIn=0 SHALL immediately force: state IDLE, pc=romAddr=RESET_ADDR, romReq=0, instValid=0, instAddr=0, flushOut=0, misalignErr=0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding ROM request; a later romAck in IDLE SHALL be ignored.
REQ-031 First romReq SHALL assert the second rising edge after resetIn deasserts (IDLE one cycle).

Configuration
REQ-032 Macro FETCH_CTRL_MISALIGN_CHK_EN defined: redirect target with bit0=1 sets misalignErr (sticky until reset) and pc takes target with bit0 cleared.
REQ-033 Macro undefined: target used unmodified; misalignErr tied 0; port still present.

Verification
REQ-034 Reset release, romAck 1 cycle after each romReq, stallIn=0 -> instAddr sequence 0,2,4,...,62,0 (wrap), instValid pulses every other cycle.
REQ-035 stallIn=1 for 5 cycles in VALID at instAddr=4 -> instValid and instAddr=4 held 5 cycles, romReq=0 throughout, then fetch of 6.
REQ-036 brReq=1 target=20 and trapReq=1 vec=40 same cycle in VALID -> flushOut one pulse, instValid drops, next romAddr=40.
REQ-037 brReq target=20 in FETCH, romAck delayed 3 cycles -> romAddr held old value through DRAIN, that ack discarded, next romReq romAddr=20.
REQ-038 Macro defined, brReq target=21 -> misalignErr=1 and stays 1, next romAddr=20; macro undefined -> romAddr=21, misalignErr=0.
REQ-039 resetIn=0 asynchronously while romReq=1 -> all outputs reset values before next edge; stray romAck after release ignored, first fetch at RESET_ADDR.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bundle: consumer handshake, redirect requests and ROM read port.
// master = fetch_ctrl side, slave = consumer/ROM/redirect environment.
interface fetch_ctrl_if #(parameter int ADDR_W = 6);
    logic              stallIn;
    logic              brReq;
    logic [ADDR_W-1:0] brTarget;
    logic              trapReq;
    logic [ADDR_W-1:0] trapVec;
    logic              romReq;
    logic [ADDR_W-1:0] romAddr;
    logic              romAck;
    logic              instValid;
    logic [ADDR_W-1:0] instAddr;
    logic              flushOut;
    logic              misalignErr;

    modport master (
        input  stallIn, brReq, brTarget, trapReq, trapVec, romAck,
        output romReq, romAddr, instValid, instAddr, flushOut, misalignErr
    );
    modport slave (
        output stallIn, brReq, brTarget, trapReq, trapVec, romAck,
        input  romReq, romAddr, instValid, instAddr, flushOut, misalignErr
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, ROM handshake, branch/trap redirect with flush.
// Optional FETCH_CTRL_MISALIGN_CHK_EN: odd redirect targets set sticky misalignErr and are rounded down.
module fetch_ctrl #(
    parameter int                ADDR_W     = 6,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                STEP       = 2
) (
    input  logic          clk,
    input  logic          resetIn,
    fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, rom_addr, rom_addr_nxt, inst_addr, inst_addr_nxt;
    logic [ADDR_W-1:0] tgt_raw, tgt;
    logic              started, inst_valid, inst_valid_nxt, flush, flush_nxt, redir;

    assign tgt_raw = bus.trapReq ? bus.trapVec : bus.brTarget;
    assign redir   = (state != IDLE) && (bus.trapReq || bus.brReq);

`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    logic mis;
    assign tgt = {tgt_raw[ADDR_W-1:1], 1'b0};
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn)                  mis <= 1'b0;
        else if (redir && tgt_raw[0])  mis <= 1'b1;
    end
    assign bus.misalignErr = mis;
`else
    assign tgt             = tgt_raw;
    assign bus.misalignErr = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        rom_addr_nxt   = rom_addr;
        inst_valid_nxt = inst_valid;
        inst_addr_nxt  = inst_addr;
        flush_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                // started delays the first request so IDLE lasts one full cycle after release
                if (started) begin
                    state_nxt    = FETCH;
                    rom_addr_nxt = pc;
                end
            end
            FETCH: begin
                if (redir) begin
                    pc_nxt         = tgt;
                    flush_nxt      = 1'b1;
                    inst_valid_nxt = 1'b0;
                    if (bus.romAck) begin
                        state_nxt    = FETCH;
                        rom_addr_nxt = tgt;
                    end else begin
                        state_nxt    = DRAIN;
                    end
                end else if (bus.romAck) begin
                    state_nxt      = VALID;
                    inst_valid_nxt = 1'b1;
                    inst_addr_nxt  = pc;
                    pc_nxt         = pc + STEP_W;
                end
            end
            VALID: begin
                if (redir) begin
                    pc_nxt         = tgt;
                    flush_nxt      = 1'b1;
                    inst_valid_nxt = 1'b0;
                    state_nxt      = FETCH;
                    rom_addr_nxt   = tgt;
                end else if (!bus.stallIn) begin
                    inst_valid_nxt = 1'b0;
                    state_nxt      = FETCH;
                    rom_addr_nxt   = pc;
                end
            end
            DRAIN: begin
                // old request stays on the bus until its ack, which is then dropped
                if (redir) begin
                    pc_nxt    = tgt;
                    flush_nxt = 1'b1;
                end
                if (bus.romAck) begin
                    state_nxt    = FETCH;
                    rom_addr_nxt = redir ? tgt : pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            state      <= IDLE;
            started    <= 1'b0;
            pc         <= RESET_ADDR;
            rom_addr   <= RESET_ADDR;
            inst_valid <= 1'b0;
            inst_addr  <= '0;
            flush      <= 1'b0;
        end else begin
            state      <= state_nxt;
            started    <= 1'b1;
            pc         <= pc_nxt;
            rom_addr   <= rom_addr_nxt;
            inst_valid <= inst_valid_nxt;
            inst_addr  <= inst_addr_nxt;
            flush      <= flush_nxt;
        end
    end

    assign bus.romReq    = (state == FETCH) || (state == DRAIN);
    assign bus.romAddr   = rom_addr;
    assign bus.instValid = inst_valid;
    assign bus.instAddr  = inst_addr;
    assign bus.flushOut  = flush;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, wrap-around sequencing, async reset, and a vector table
// covering stall, redirect priority, drain, and misaligned targets.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic resetIn;
    int   errors = 0;
    int   checks = 0;

    fetch_ctrl_if #(.ADDR_W(6)) bus();

    fetch_ctrl #(.ADDR_W(6), .RESET_ADDR(6'd0), .STEP(2)) dut (
        .clk(clk), .resetIn(resetIn), .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef FETCH_CTRL_MISALIGN_CHK_EN
    localparam logic [5:0] A21 = 6'd20;
    localparam logic       MIS = 1'b1;
`else
    localparam logic [5:0] A21 = 6'd21;
    localparam logic       MIS = 1'b0;
`endif

    typedef struct {
        logic stall; logic br; logic [5:0] brt; logic trap; logic [5:0] tv; logic ack;
        logic req; logic [5:0] addr; logic vld; logic [5:0] ia; logic fl; logic mis;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        bus.stallIn = 0; bus.brReq = 0; bus.brTarget = '0;
        bus.trapReq = 0; bus.trapVec = '0; bus.romAck = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".romReq"},      bus.romReq,      0);
        chk({tag, ".romAddr"},     bus.romAddr,     0);
        chk({tag, ".instValid"},   bus.instValid,   0);
        chk({tag, ".instAddr"},    bus.instAddr,    0);
        chk({tag, ".flushOut"},    bus.flushOut,    0);
        chk({tag, ".misalignErr"}, bus.misalignErr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clr_inputs();
        resetIn = 1'b0;
        #3;
        chk_reset_outs("reset");

        // release between edges: IDLE for one full cycle, romReq from the second edge
        @(negedge clk); resetIn = 1'b1;
        @(posedge clk); #1;
        chk("first_edge.romReq", bus.romReq, 0);
        @(posedge clk); #1;
        chk("second_edge.romReq", bus.romReq, 1);
        chk("second_edge.romAddr", bus.romAddr, 0);

        // back-to-back fetches with immediate ack: 0,2,...,62,0
        for (int k = 0; k <= 32; k++) begin
            logic [5:0] ea, en;
            ea = 6'(k * 2);
            en = 6'((k + 1) * 2);
            @(negedge clk); bus.romAck = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("wrap%0d.instValid", k), bus.instValid, 1);
            chk($sformatf("wrap%0d.instAddr", k),  bus.instAddr,  ea);
            @(negedge clk); bus.romAck = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("wrap%0d.gap", k),     bus.instValid, 0);
            chk($sformatf("wrap%0d.romReq", k),  bus.romReq,    1);
            chk($sformatf("wrap%0d.romAddr", k), bus.romAddr,   en);
        end

        // async reset while a request is outstanding (romAddr=2 here)
        #2 resetIn = 1'b0;
        #1 chk_reset_outs("async_reset");
        bus.romAck = 1'b1;
        @(posedge clk);
        @(negedge clk); resetIn = 1'b1;
        @(posedge clk); #1;
        chk("stray_ack.idle_romReq", bus.romReq, 0);
        chk("stray_ack.idle_valid",  bus.instValid, 0);
        @(posedge clk); #1;
        chk("post_reset.romReq",  bus.romReq, 1);
        chk("post_reset.romAddr", bus.romAddr, 0);
        chk("post_reset.valid",   bus.instValid, 0);
        @(negedge clk); bus.romAck = 1'b0;
        @(posedge clk); #1;
        chk("post_reset.still_fetch", bus.romReq, 1);
        chk("post_reset.no_valid",    bus.instValid, 0);

        // vector table: {stall,br,brt,trap,tv,ack | req,addr,vld,ia,flush,mis}
        vq.push_back('{0,0, 0,0, 0,0, 0, 0,0, 0,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1, 0,0, 0,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 0, 0,1, 0,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1, 2,0, 0,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 0, 2,1, 2,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1, 4,0, 2,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 0, 4,1, 4,0,0});
        for (int i = 0; i < 5; i++) vq.push_back('{1,0, 0,0, 0,0, 0, 4,1, 4,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1, 6,0, 4,0,0});
        vq.push_back('{1,0, 0,0, 0,1, 0, 6,1, 6,0,0});
        vq.push_back('{1,1,20,1,40,0, 1,40,0, 6,1,0});
        vq.push_back('{0,0, 0,0, 0,0, 1,40,0, 6,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 0,40,1,40,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1,42,0,40,0,0});
        vq.push_back('{0,1,20,0, 0,0, 1,42,0,40,1,0});
        vq.push_back('{0,0, 0,0, 0,0, 1,42,0,40,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1,42,0,40,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 1,20,0,40,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 0,20,1,20,0,0});
        vq.push_back('{0,0, 0,0, 0,0, 1,22,0,20,0,0});
        vq.push_back('{0,0, 0,1,10,1, 1,10,0,20,1,0});
        vq.push_back('{0,1,30,0, 0,0, 1,10,0,20,1,0});
        vq.push_back('{0,0, 0,1,50,0, 1,10,0,20,1,0});
        vq.push_back('{0,0, 0,0, 0,1, 1,50,0,20,0,0});
        vq.push_back('{0,0, 0,0, 0,1, 0,50,1,50,0,0});
        vq.push_back('{0,1,21,0, 0,0, 1,A21,0,50,1,MIS});
        vq.push_back('{0,0, 0,0, 0,1, 0,A21,1,A21,0,MIS});
        vq.push_back('{0,0, 0,0, 0,0, 1,A21+6'd2,0,A21,0,MIS});

        @(negedge clk); resetIn = 1'b0; clr_inputs();
        @(negedge clk); resetIn = 1'b1;
        foreach (vq[i]) begin
            bus.stallIn = vq[i].stall; bus.brReq = vq[i].br; bus.brTarget = vq[i].brt;
            bus.trapReq = vq[i].trap;  bus.trapVec = vq[i].tv; bus.romAck = vq[i].ack;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.romReq", i),      bus.romReq,      vq[i].req);
            chk($sformatf("vec%0d.romAddr", i),     bus.romAddr,     vq[i].addr);
            chk($sformatf("vec%0d.instValid", i),   bus.instValid,   vq[i].vld);
            chk($sformatf("vec%0d.instAddr", i),    bus.instAddr,    vq[i].ia);
            chk($sformatf("vec%0d.flushOut", i),    bus.flushOut,    vq[i].fl);
            chk($sformatf("vec%0d.misalignErr", i), bus.misalignErr, vq[i].mis);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
